// File: rtl/serial_tx.sv
// serial_tx -- UART transmitter, last stage before the board's serial pin.
//
// Accepts one byte per handshake (uart_clock_enable high while uart_ready
// high, sampled on the rising clock edge) and sends it as a frame:
//   start bit (0), 8 data bits LSB first, optional parity bit, 1 or 2 stop bits (1).
// Every bit lasts exactly CLOCK_DIV clock cycles.
//
// Parameters:
//   CLOCK_DIV  clock cycles per bit period (2..65535)
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  1 or 2
//
// Ports:
//   clock              system clock, rising edge
//   reset              asynchronous, active-high; aborts any frame in flight
//   uart_data          byte to send, latched on accept
//   uart_clock_enable  level request: byte valid on uart_data
//   uart_ready         high = idle, able to accept a byte (registered)
//   tx                 serial line, idle high (registered)
//   tx_done            one-cycle pulse when a frame's last stop bit ends
module serial_tx #(
  parameter int CLOCK_DIV = 104,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] uart_data,
  input  logic       uart_clock_enable,
  output logic       uart_ready,
  output logic       tx,
  output logic       tx_done
);

  localparam int TW = $clog2(CLOCK_DIV) + 1;
  localparam logic [TW-1:0] BIT_LOAD  = TW'(CLOCK_DIV - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            par_bit;

  // Even parity is the XOR of the byte; odd parity is its complement.
  function automatic logic parity_of(input logic [7:0] b);
    return (^b) ^ (PARITY == 1);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tx         <= 1'b1;
      uart_ready <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (uart_clock_enable) begin
            shreg      <= uart_data;
            par_bit    <= parity_of(uart_data);
            timer      <= BIT_LOAD;
            bit_idx    <= '0;
            tx         <= 1'b0;
            uart_ready <= 1'b0;
            state      <= S_START;
          end
        end

        S_START: begin
          if (timer == '0) begin
            timer   <= BIT_LOAD;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= S_DATA;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        S_DATA: begin
          if (timer == '0) begin
            timer <= BIT_LOAD;
            if (bit_idx == 3'd7) begin
              if (PARITY != 0) begin
                tx    <= par_bit;
                state <= S_PARITY;
              end else begin
                tx      <= 1'b1;
                bit_idx <= '0;
                state   <= S_STOP;
              end
            end else begin
              // shreg[1] is the next bit, shifted down as it goes out
              tx      <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        S_PARITY: begin
          if (timer == '0) begin
            timer   <= BIT_LOAD;
            bit_idx <= '0;
            tx      <= 1'b1;
            state   <= S_STOP;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        S_STOP: begin
          if (timer == '0) begin
            if (bit_idx == LAST_STOP) begin
              tx_done <= 1'b1;
              // A request still pending at frame end starts the next frame
              // on this very edge, so the start bit follows with no idle gap.
              if (uart_clock_enable) begin
                shreg      <= uart_data;
                par_bit    <= parity_of(uart_data);
                timer      <= BIT_LOAD;
                bit_idx    <= '0;
                tx         <= 1'b0;
                uart_ready <= 1'b0;
                state      <= S_START;
              end else begin
                tx         <= 1'b1;
                uart_ready <= 1'b1;
                state      <= S_IDLE;
              end
            end else begin
              timer   <= BIT_LOAD;
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        default: begin
          tx         <= 1'b1;
          uart_ready <= 1'b1;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: four instances with CLOCK_DIV=4
//   k=0: no parity, 1 stop   k=1: even parity, 1 stop
//   k=2: odd parity, 1 stop  k=3: no parity, 2 stops
module tb_serial_tx;

  localparam int DIV = 4;

  logic       clock;
  logic       reset;
  logic [7:0] data [4];
  logic       en   [4];
  logic       rdy  [4];
  logic       txl  [4];
  logic       done [4];

  int checks;
  int failures;

  logic exp_bits [$];
  int   done_q   [$];

  serial_tx #(.CLOCK_DIV(DIV), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clock(clock), .reset(reset), .uart_data(data[0]), .uart_clock_enable(en[0]),
    .uart_ready(rdy[0]), .tx(txl[0]), .tx_done(done[0]));
  serial_tx #(.CLOCK_DIV(DIV), .PARITY(2), .STOP_BITS(1)) dut1 (
    .clock(clock), .reset(reset), .uart_data(data[1]), .uart_clock_enable(en[1]),
    .uart_ready(rdy[1]), .tx(txl[1]), .tx_done(done[1]));
  serial_tx #(.CLOCK_DIV(DIV), .PARITY(1), .STOP_BITS(1)) dut2 (
    .clock(clock), .reset(reset), .uart_data(data[2]), .uart_clock_enable(en[2]),
    .uart_ready(rdy[2]), .tx(txl[2]), .tx_done(done[2]));
  serial_tx #(.CLOCK_DIV(DIV), .PARITY(0), .STOP_BITS(2)) dut3 (
    .clock(clock), .reset(reset), .uart_data(data[3]), .uart_clock_enable(en[3]),
    .uart_ready(rdy[3]), .tx(txl[3]), .tx_done(done[3]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int pmode(input int k);
    return (k == 1) ? 2 : (k == 2) ? 1 : 0;
  endfunction

  function automatic int nstop(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  // Push the expected line value of every bit period of one frame.
  task automatic push_frame(input int k, input logic [7:0] b);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    if (pmode(k) == 2) exp_bits.push_back(^b);
    if (pmode(k) == 1) exp_bits.push_back(~(^b));
    for (int i = 0; i < nstop(k); i++) exp_bits.push_back(1'b1);
  endtask

  // Drive one request; returns #1 after the accepting edge.
  task automatic accept(input int k, input logic [7:0] b, input bit hold);
    @(negedge clock);
    data[k] = b;
    en[k]   = 1'b1;
    @(posedge clock);
    #1;
    if (!hold) en[k] = 1'b0;
  endtask

  // Scoreboard consumer: cycle c is sampled on the falling edge after
  // accept edge + c. Optional stimulus hooks fire at given cycles.
  task automatic score(input int k, input int ncyc, input int busy, input string tag,
                       input int c_mid, input logic [7:0] mid_data, input logic mid_en,
                       input int c_en_off);
    logic cur;
    logic exp_done;
    cur = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      if (c < busy && (c % DIV) == 0) begin
        if (exp_bits.size() > 0) cur = exp_bits.pop_front();
        else cur = 1'b1;
      end
      if (c >= busy) cur = 1'b1;
      checks++;
      if (txl[k] !== cur) begin
        failures++;
        $display("FAIL %s tx cycle %0d: got %b want %b", tag, c, txl[k], cur);
      end
      checks++;
      if (rdy[k] !== (c >= busy)) begin
        failures++;
        $display("FAIL %s uart_ready cycle %0d: got %b want %b", tag, c, rdy[k], (c >= busy));
      end
      exp_done = 1'b0;
      if (done_q.size() > 0 && done_q[0] == c) begin
        exp_done = 1'b1;
        void'(done_q.pop_front());
      end
      checks++;
      if (done[k] !== exp_done) begin
        failures++;
        $display("FAIL %s tx_done cycle %0d: got %b want %b", tag, c, done[k], exp_done);
      end
      if (c == c_mid) begin
        data[k] = mid_data;
        en[k]   = mid_en;
      end
      if (c == c_en_off) en[k] = 1'b0;
    end
    checks++;
    if (exp_bits.size() != 0 || done_q.size() != 0) begin
      failures++;
      $display("FAIL %s scoreboard leftover: bits=%0d dones=%0d want 0 0", tag,
               exp_bits.size(), done_q.size());
    end
    exp_bits.delete();
    done_q.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data[k] = 8'h00;
      en[k]   = 1'b0;
    end
    repeat (3) @(posedge clock);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (txl[k] !== 1'b1 || rdy[k] !== 1'b1 || done[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset dut%0d: tx/ready/done=%b%b%b want 110", k, txl[k], rdy[k], done[k]);
      end
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_basic;
    push_frame(0, 8'h55);
    done_q.push_back(40);
    accept(0, 8'h55, 1'b0);
    score(0, 43, 40, "basic_55", -1, 8'h00, 1'b0, -1);
  endtask

  task automatic test_parity;
    push_frame(1, 8'h07);
    done_q.push_back(44);
    accept(1, 8'h07, 1'b0);
    score(1, 46, 44, "even_07", -1, 8'h00, 1'b0, -1);
    push_frame(2, 8'h07);
    done_q.push_back(44);
    accept(2, 8'h07, 1'b0);
    score(2, 46, 44, "odd_07", -1, 8'h00, 1'b0, -1);
    push_frame(1, 8'hB4);
    done_q.push_back(44);
    accept(1, 8'hB4, 1'b0);
    score(1, 46, 44, "even_b4", -1, 8'h00, 1'b0, -1);
  endtask

  task automatic test_two_stop;
    push_frame(3, 8'hA3);
    done_q.push_back(44);
    accept(3, 8'hA3, 1'b0);
    score(3, 46, 44, "stop2_a3", -1, 8'h00, 1'b0, -1);
  endtask

  task automatic test_back_to_back;
    push_frame(0, 8'h0A);
    push_frame(0, 8'h0D);
    done_q.push_back(40);
    done_q.push_back(80);
    accept(0, 8'h0A, 1'b1);
    // 0x0D is on the bus by the first frame's end; enable drops after it is taken
    score(0, 83, 80, "b2b", 20, 8'h0D, 1'b1, 40);
  endtask

  task automatic test_midframe_ignore;
    push_frame(0, 8'h3C);
    done_q.push_back(40);
    accept(0, 8'h3C, 1'b0);
    score(0, 43, 40, "ignore", 15, 8'hFF, 1'b1, 17);
  endtask

  task automatic test_reset_abort;
    accept(0, 8'hC6, 1'b0);
    // Cycle 17 sits in data bit 3 (frame bit 4); bit 3 of 0xC6 is 0.
    repeat (18) @(negedge clock);
    checks++;
    if (txl[0] !== 1'b0) begin
      failures++;
      $display("FAIL abort pre-reset tx: got %b want 0", txl[0]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (txl[0] !== 1'b1 || rdy[0] !== 1'b1 || done[0] !== 1'b0) begin
      failures++;
      $display("FAIL abort async tx/ready/done=%b%b%b want 110", txl[0], rdy[0], done[0]);
    end
    repeat (2) begin
      @(negedge clock);
      checks++;
      if (done[0] !== 1'b0 || txl[0] !== 1'b1) begin
        failures++;
        $display("FAIL abort held tx/done=%b%b want 10", txl[0], done[0]);
      end
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (done[0] !== 1'b0 || rdy[0] !== 1'b1 || txl[0] !== 1'b1) begin
        failures++;
        $display("FAIL abort after release tx/ready/done=%b%b%b want 110", txl[0], rdy[0], done[0]);
      end
    end
    push_frame(0, 8'h41);
    done_q.push_back(40);
    accept(0, 8'h41, 1'b0);
    score(0, 43, 40, "after_abort_41", -1, 8'h00, 1'b0, -1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_parity();
    test_two_stop();
    test_back_to_back();
    test_midframe_ignore();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
UART transmitter that sits directly downstream of the FIFO-to-serial byte formatter. It accepts one byte per handshake on uart_data/uart_clock_enable/uart_ready. It serialises each byte onto a single TX line: one start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. It is the last stage before the board's serial pin.

Parameters:
CLOCK_DIV, 104, clock cycles per bit period (12 MHz / 115200); legal range 2..65535.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clock  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
uart_data  input  8  byte to send; sampled only on accept.
uart_clock_enable  input  1  level request: byte valid on uart_data.
uart_ready  output  1  high = idle, able to accept a byte.
tx  output  1  serial line; idle high.
tx_done  output  1  one-cycle pulse at end of each frame's last stop bit.

Behaviour:
- Reset (async, while reset=1): tx=1, uart_ready=1, tx_done=0, state=IDLE, counters=0, shift register cleared. Reset mid-frame aborts the frame immediately: tx returns high asynchronously and the byte is lost. No tx_done for the aborted byte.
- Accept rule: a byte is accepted on a rising edge where uart_ready=1 and uart_clock_enable=1. At that edge, uart_data is latched into an internal shift register and the parity bit is computed from the latched value.
- From the edge after accept (N+1): uart_ready=0 and tx=0 (start bit). All outputs are registered.
- uart_ready stays 0 for exactly F*CLOCK_DIV cycles, where F = 1 + 8 + (PARITY!=0) + STOP_BITS. It returns to 1 on the same edge the last stop-bit period ends.
- uart_clock_enable and uart_data are ignored while uart_ready=0. Changing uart_data mid-frame does not affect the frame.
- Level semantics: if uart_clock_enable is still high when uart_ready returns to 1, a new byte is accepted on that edge. The next start bit then follows the stop bit with zero idle gap. The upstream formatter deasserts its enable once it sees uart_ready low.
- State machine:
  - IDLE: tx=1; go to START on accept.
  - START: tx=0 for CLOCK_DIV cycles, then DATA.
  - DATA: bit i driven for CLOCK_DIV cycles, i=0..7, LSB first; 3-bit bit index. After bit 7, go to PARITY if PARITY!=0, else STOP.
  - PARITY: tx = XOR(byte) for even, or ~XOR(byte) for odd, for CLOCK_DIV cycles, then STOP.
  - STOP: tx=1 for STOP_BITS*CLOCK_DIV cycles, then IDLE.
- Bit timer: down-counter of width clog2(CLOCK_DIV)+1. It loads CLOCK_DIV-1 on each bit start and advances the bit or state when it reaches 0. No drift: every bit is exactly CLOCK_DIV cycles.
- tx_done: high for exactly one cycle, the cycle uart_ready first returns to 1 after a frame. It is not asserted on an abort.
- tx never glitches: it is driven from a flop only.

Test Plan:
1. CLOCK_DIV=4, PARITY=0, STOP_BITS=1. Pulse enable one cycle with 0x55 -> tx, one sample per 4 cycles, reads 0,1,0,1,0,1,0,1,0,1. uart_ready low exactly 40 cycles. One tx_done pulse.
2. PARITY=2 (even), send 0x07 -> parity bit 1; PARITY=1 (odd), send 0x07 -> parity bit 0. Frame is 44 cycles with CLOCK_DIV=4.
3. STOP_BITS=2, send 0xA3 -> data bits 1,1,0,0,0,1,0,1, then tx high for 8 cycles. uart_ready low 44 cycles.
4. Hold enable high with data 0x0A, then 0x0D -> the second start bit begins on the edge after the first frame's stop bit ends, with no idle cycle. Two tx_done pulses 40 cycles apart.
5. Mid-frame, toggle uart_data to 0xFF and pulse enable -> no effect; the original byte is transmitted intact and uart_ready stays low.
6. Assert reset during data bit 3 -> tx=1 and uart_ready=1 asynchronously, with no tx_done. After release, sending 0x41 produces a correct, clean frame.
